// File: rtl/lcl_arb_pkg.sv
// Shared types and constants for the local-bus arbiter: FSM encoding,
// response codes and bus widths.
package lcl_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic RSP_OKAY = 1'b1;
  localparam logic RSP_ERR  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/lcl_bus_arbiter_if.sv
// Requester-side and master-side signals of the local-bus arbiter.
// The arbiter uses the slave view; the surrounding logic uses the master view.
interface lcl_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import lcl_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [NUM_REQ-1:0]        req_gnt;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_rsp;
  logic [DATA_W-1:0]         req_dout;

  logic                      lcl_wr;
  logic                      lcl_rd;
  logic [ADDR_W-1:0]         lcl_addr;
  logic [DATA_W-1:0]         lcl_din;
  logic                      lcl_ack;
  logic                      lcl_dv;
  logic                      lcl_rsp;
  logic [DATA_W-1:0]         lcl_dout;

  modport slave (
    input  req_wr, req_rd, req_addr, req_din,
    input  lcl_ack, lcl_dv, lcl_rsp, lcl_dout,
    output req_gnt, req_done, req_rsp, req_dout,
    output lcl_wr, lcl_rd, lcl_addr, lcl_din
  );

  modport master (
    output req_wr, req_rd, req_addr, req_din,
    output lcl_ack, lcl_dv, lcl_rsp, lcl_dout,
    input  req_gnt, req_done, req_rsp, req_dout,
    input  lcl_wr, lcl_rd, lcl_addr, lcl_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping, returned both one-hot and as an index.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o                       = 1'b1;
        idx_o                         = IDX_W'((int'(ptr_i) + i) % N);
        gnt_o[(int'(ptr_i) + i) % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcl_bus_arbiter.sv
// Shares one local-bus master port among NUM_REQ requesters: one transaction
// in flight, round-robin selection, and a per-transaction timeout.
module lcl_bus_arbiter
  import lcl_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  lcl_bus_arbiter_if.slave  bus,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_stray,
  input  logic              err_clr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] win_oh_q;
  logic               op_wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] req_gnt_q;
  logic [NUM_REQ-1:0] req_done_q;
  logic               req_rsp_q;
  logic [DATA_W-1:0]  req_dout_q;
  logic               lcl_wr_q;
  logic               lcl_rd_q;
  logic [ADDR_W-1:0]  lcl_addr_q;
  logic [DATA_W-1:0]  lcl_din_q;
  logic               busy_q;
  logic               err_timeout_q;
  logic               err_stray_q;

  logic [NUM_REQ-1:0] req_any;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               cpl;
  logic               tmo;
  logic               stray;

  assign req_any = bus.req_wr | bus.req_rd;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_any),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // A completion of the wrong type is never taken as completion; it only flags stray.
  assign cpl   = (state_q == WAIT) && (op_wr_q ? bus.lcl_ack : bus.lcl_dv);
  assign tmo   = (state_q == WAIT) && !cpl && (cnt_q == CNT_LAST);
  assign stray = (state_q != WAIT) ? (bus.lcl_ack | bus.lcl_dv)
                                   : (op_wr_q ? bus.lcl_dv : bus.lcl_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_oh_q      <= '0;
      op_wr_q       <= 1'b0;
      cnt_q         <= '0;
      req_gnt_q     <= '0;
      req_done_q    <= '0;
      req_rsp_q     <= RSP_ERR;
      req_dout_q    <= '0;
      lcl_wr_q      <= 1'b0;
      lcl_rd_q      <= 1'b0;
      lcl_addr_q    <= '0;
      lcl_din_q     <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      lcl_wr_q   <= 1'b0;
      lcl_rd_q   <= 1'b0;
      req_gnt_q  <= '0;
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            win_oh_q   <= arb_gnt;
            op_wr_q    <= bus.req_wr[arb_idx];
            lcl_wr_q   <= bus.req_wr[arb_idx];
            lcl_rd_q   <= ~bus.req_wr[arb_idx];
            req_gnt_q  <= arb_gnt;
            lcl_addr_q <= bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            lcl_din_q  <= bus.req_din[int'(arb_idx)*DATA_W +: DATA_W];
            ptr_q      <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cpl) begin
            state_q    <= DONE;
            req_done_q <= win_oh_q;
            req_rsp_q  <= bus.lcl_rsp;
            req_dout_q <= op_wr_q ? '0 : bus.lcl_dout;
          end else if (tmo) begin
            state_q    <= DONE;
            req_done_q <= win_oh_q;
            req_rsp_q  <= RSP_ERR;
            req_dout_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      if (tmo)          err_timeout_q <= 1'b1;
      else if (err_clr) err_timeout_q <= 1'b0;
      if (stray)        err_stray_q   <= 1'b1;
      else if (err_clr) err_stray_q   <= 1'b0;
    end
  end

  assign bus.req_gnt  = req_gnt_q;
  assign bus.req_done = req_done_q;
  assign bus.req_rsp  = req_rsp_q;
  assign bus.req_dout = req_dout_q;
  assign bus.lcl_wr   = lcl_wr_q;
  assign bus.lcl_rd   = lcl_rd_q;
  assign bus.lcl_addr = lcl_addr_q;
  assign bus.lcl_din  = lcl_din_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;
  assign err_stray    = err_stray_q;

endmodule

// File: tb/tb_lcl_bus_arbiter.sv
// Directed bench for lcl_bus_arbiter: write, read, round-robin order,
// write-before-read, error response, timeout, stray replies, reset mid-flight.
module tb_lcl_bus_arbiter;

  localparam int NR = 4;

  logic clk;
  logic rst_n;
  logic busy;
  logic err_timeout;
  logic err_stray;
  logic err_clr;
  int   checks = 0;
  int   errors = 0;

  lcl_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  lcl_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_stray   (err_stray),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    err_clr      = 1'b0;
    bus.req_wr   = '0;
    bus.req_rd   = '0;
    bus.req_addr = '0;
    bus.req_din  = '0;
    bus.lcl_ack  = 1'b0;
    bus.lcl_dv   = 1'b0;
    bus.lcl_rsp  = 1'b0;
    bus.lcl_dout = '0;

    // Reset state
    tick();
    tick();
    chkb("rst_busy",   busy, 1'b0);
    chk ("rst_gnt",    32'(bus.req_gnt), 32'h0);
    chk ("rst_done",   32'(bus.req_done), 32'h0);
    chkb("rst_lcl_wr", bus.lcl_wr, 1'b0);
    chkb("rst_lcl_rd", bus.lcl_rd, 1'b0);
    chk ("rst_addr",   bus.lcl_addr, 32'h0);
    chkb("rst_rsp",    bus.req_rsp, 1'b0);
    chkb("rst_etmo",   err_timeout, 1'b0);
    chkb("rst_estray", err_stray, 1'b0);
    rst_n = 1'b1;

    // Fairness: everyone writes continuously, master acks in the first WAIT cycle
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[32*i +: 32] = 32'h100 + 32'(4*i);
      bus.req_din[32*i +: 32]  = 32'hF0 + 32'(i);
    end
    bus.req_wr = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk ("fair_gnt",  32'(bus.req_gnt), 32'(1 << (k % 4)));
      chkb("fair_wr",   bus.lcl_wr, 1'b1);
      chk ("fair_addr", bus.lcl_addr, 32'h100 + 32'(4*(k % 4)));
      chk ("fair_din",  bus.lcl_din, 32'hF0 + 32'(k % 4));
      tick();
      chkb("fair_one_strobe", bus.lcl_wr, 1'b0);
      bus.lcl_ack = 1'b1;
      bus.lcl_rsp = 1'b1;
      tick();
      bus.lcl_ack = 1'b0;
      chk ("fair_done", 32'(bus.req_done), 32'(1 << (k % 4)));
      chkb("fair_rsp",  bus.req_rsp, 1'b1);
      tick();
      chkb("fair_idle", busy, 1'b0);
      chk ("fair_done_pulse", 32'(bus.req_done), 32'h0);
    end
    bus.req_wr = '0;
    chkb("fair_no_stray", err_stray, 1'b0);

    // Single write from requester 1, acked after 3 WAIT cycles
    bus.req_addr[32*1 +: 32] = 32'h0000_0010;
    bus.req_din[32*1 +: 32]  = 32'hDEAD_BEEF;
    bus.req_wr = 4'b0010;
    tick();
    chkb("wr_strobe", bus.lcl_wr, 1'b1);
    chkb("wr_no_rd",  bus.lcl_rd, 1'b0);
    chk ("wr_addr",   bus.lcl_addr, 32'h0000_0010);
    chk ("wr_din",    bus.lcl_din, 32'hDEAD_BEEF);
    chk ("wr_gnt",    32'(bus.req_gnt), 32'h2);
    chkb("wr_busy",   busy, 1'b1);
    bus.req_wr = '0;
    tick();
    chkb("wr_strobe_off", bus.lcl_wr, 1'b0);
    chk ("wr_gnt_off",    32'(bus.req_gnt), 32'h0);
    tick();
    tick();
    chk ("wr_wait_done", 32'(bus.req_done), 32'h0);
    bus.lcl_ack = 1'b1;
    bus.lcl_rsp = 1'b1;
    tick();
    bus.lcl_ack = 1'b0;
    chk ("wr_done",      32'(bus.req_done), 32'h2);
    chkb("wr_rsp",       bus.req_rsp, 1'b1);
    chk ("wr_addr_hold", bus.lcl_addr, 32'h0000_0010);
    tick();
    chk ("wr_done_off", 32'(bus.req_done), 32'h0);
    chkb("wr_idle",     busy, 1'b0);
    chkb("wr_rsp_hold", bus.req_rsp, 1'b1);

    // Single read from requester 2
    bus.req_addr[32*2 +: 32] = 32'h0000_0020;
    bus.req_rd = 4'b0100;
    tick();
    chkb("rd_strobe", bus.lcl_rd, 1'b1);
    chkb("rd_no_wr",  bus.lcl_wr, 1'b0);
    chk ("rd_gnt",    32'(bus.req_gnt), 32'h4);
    chk ("rd_addr",   bus.lcl_addr, 32'h0000_0020);
    bus.req_rd = '0;
    tick();
    bus.lcl_dv   = 1'b1;
    bus.lcl_rsp  = 1'b1;
    bus.lcl_dout = 32'h1234_5678;
    tick();
    bus.lcl_dv = 1'b0;
    chk ("rd_done", 32'(bus.req_done), 32'h4);
    chkb("rd_rsp",  bus.req_rsp, 1'b1);
    chk ("rd_dout", bus.req_dout, 32'h1234_5678);
    tick();
    chk ("rd_dout_hold", bus.req_dout, 32'h1234_5678);

    // Requester 3 asks for write and read together: write first, read later
    bus.req_addr[32*3 +: 32] = 32'h0000_0030;
    bus.req_wr = 4'b1000;
    bus.req_rd = 4'b1000;
    tick();
    chkb("wr1st_wr", bus.lcl_wr, 1'b1);
    chkb("wr1st_rd", bus.lcl_rd, 1'b0);
    chk ("wr1st_gnt", 32'(bus.req_gnt), 32'h8);
    bus.req_wr = '0;
    tick();
    bus.lcl_ack = 1'b1;
    bus.lcl_rsp = 1'b1;
    tick();
    bus.lcl_ack = 1'b0;
    chk ("wr1st_done", 32'(bus.req_done), 32'h8);
    chk ("wr1st_dout", bus.req_dout, 32'h0);
    tick();
    tick();
    chkb("rd2nd_rd", bus.lcl_rd, 1'b1);
    chkb("rd2nd_wr", bus.lcl_wr, 1'b0);
    chk ("rd2nd_gnt", 32'(bus.req_gnt), 32'h8);
    bus.req_rd = '0;
    tick();
    bus.lcl_dv   = 1'b1;
    bus.lcl_dout = 32'h0BAD_C0DE;
    tick();
    bus.lcl_dv = 1'b0;
    chk ("rd2nd_done", 32'(bus.req_done), 32'h8);
    chk ("rd2nd_dout", bus.req_dout, 32'h0BAD_C0DE);
    tick();

    // Error response on a read, preceded by a wrong-type ack that must be ignored
    bus.req_addr[32*0 +: 32] = 32'h0000_0040;
    bus.req_rd = 4'b0001;
    tick();
    bus.req_rd = '0;
    tick();
    bus.lcl_ack = 1'b1;
    tick();
    bus.lcl_ack = 1'b0;
    chk ("wrongtype_no_done", 32'(bus.req_done), 32'h0);
    chkb("wrongtype_busy",    busy, 1'b1);
    chkb("wrongtype_stray",   err_stray, 1'b1);
    bus.lcl_dv   = 1'b1;
    bus.lcl_rsp  = 1'b0;
    bus.lcl_dout = 32'hA5A5_5A5A;
    tick();
    bus.lcl_dv = 1'b0;
    chk ("errrsp_done", 32'(bus.req_done), 32'h1);
    chkb("errrsp_rsp",  bus.req_rsp, 1'b0);
    chk ("errrsp_dout", bus.req_dout, 32'hA5A5_5A5A);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chkb("errrsp_clr_stray", err_stray, 1'b0);

    // Timeout: master never answers, abort 16 cycles after WAIT entry
    bus.req_addr[32*2 +: 32] = 32'h0000_0050;
    bus.req_wr = 4'b0100;
    tick();
    bus.req_wr = '0;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk ("tmo_not_yet",  32'(bus.req_done), 32'h0);
    chkb("tmo_busy",     busy, 1'b1);
    chkb("tmo_flag_pre", err_timeout, 1'b0);
    tick();
    chk ("tmo_done",   32'(bus.req_done), 32'h4);
    chkb("tmo_rsp",    bus.req_rsp, 1'b0);
    chk ("tmo_dout",   bus.req_dout, 32'h0);
    chkb("tmo_flag",   err_timeout, 1'b1);
    chkb("tmo_nostray", err_stray, 1'b0);
    tick();
    bus.lcl_ack = 1'b1;
    bus.lcl_rsp = 1'b1;
    tick();
    bus.lcl_ack = 1'b0;
    chkb("late_stray",   err_stray, 1'b1);
    chk ("late_no_done", 32'(bus.req_done), 32'h0);
    chkb("late_idle",    busy, 1'b0);
    tick();
    chk ("late_no_done2", 32'(bus.req_done), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chkb("clr_tmo",   err_timeout, 1'b0);
    chkb("clr_stray", err_stray, 1'b0);

    // Reset while waiting for the master
    bus.req_addr[32*1 +: 32] = 32'h0000_0060;
    bus.req_rd = 4'b0010;
    tick();
    bus.req_rd = '0;
    tick();
    chk ("midrst_addr_pre", bus.lcl_addr, 32'h0000_0060);
    rst_n = 1'b0;
    tick();
    chkb("midrst_busy", busy, 1'b0);
    chk ("midrst_done", 32'(bus.req_done), 32'h0);
    chk ("midrst_gnt",  32'(bus.req_gnt), 32'h0);
    chk ("midrst_addr", bus.lcl_addr, 32'h0);
    chkb("midrst_rd",   bus.lcl_rd, 1'b0);
    chk ("midrst_dout", bus.req_dout, 32'h0);
    rst_n = 1'b1;
    tick();
    chk ("midrst_done2", 32'(bus.req_done), 32'h0);
    chkb("midrst_busy2", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
